// File: rtl/pipe_reg.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshaking and bubble collapsing.
// Define PIPE_REG_COUNT_EN to add the occupancy counter and its count output.
module pipe_reg #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             accept;

  // A stage may load when any stage at or after it is empty, or the tail is draining.
  always_comb begin
    logic space;
    space = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      space   = space | ~valid_q[i];
      load[i] = space;
    end
  end

  assign in_ready  = load[0] & resetn & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[DEPTH-1] & resetn & ~flush;
  assign out_data  = resetn ? data_q[DEPTH-1] : RESET_VAL;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (load[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        data_d[0] = in_data;
      end
    end
    // Only valid data is copied forward, so a bubble never overwrites a held value.
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef PIPE_REG_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic          outXfer;

  assign outXfer = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (accept && !outXfer) begin
      count_d = count_q + CW'(1);
    end else if (!accept && outXfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Testbench for pipe_reg: directed scenarios plus random traffic against a queue-based model.
// The model tracks accepted items and derives when each reaches the output from accept times.
module tb_pipe_reg;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic         clk = 1'b0;
  logic         resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
`ifdef PIPE_REG_COUNT_EN
  logic [CW-1:0] count;
`endif

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_REG_COUNT_EN
    ,
    .count    (count)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } item_t;

  item_t pipeQ[$];
  int    cycle     = 0;
  int    lastLeave = -100;
  int    errors    = 0;
  int    checks    = 0;
  bit    known     = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, then advance the model.
  task automatic applyStimulus(input bit rstN, input bit fl, input bit iv, input logic [W-1:0] id,
                               input bit ordy, output bit accepted);
    bit    expReady, expValid;
    int    headAt;
    item_t it;
    resetn    = rstN;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    expReady = rstN && !fl && (pipeQ.size() < D || ordy);
    expValid = 1'b0;
    if (rstN && !fl && pipeQ.size() > 0) begin
      headAt = pipeQ[0].acc + D;
      if (lastLeave + 1 > headAt) headAt = lastLeave + 1;
      expValid = (headAt <= cycle);
    end
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
    if (!rstN) checkOutput("out_data_reset", {24'd0, out_data}, 32'd0);
    else if (expValid) checkOutput("out_data", {24'd0, out_data}, {24'd0, pipeQ[0].data});
`ifdef PIPE_REG_COUNT_EN
    if (known) checkOutput("count", 32'(count), 32'(pipeQ.size()));
`endif
    accepted = expReady && iv;
    if (!rstN || fl) begin
      pipeQ.delete();
      lastLeave = -100;
      if (!rstN) known = 1'b1;
    end else begin
      if (expValid && ordy) begin
        void'(pipeQ.pop_front());
        lastLeave = cycle;
      end
      if (accepted) begin
        it.data = id;
        it.acc  = cycle;
        pipeQ.push_back(it);
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    bit           acc;
    logic [W-1:0] nextData;

    // Reset held for two cycles while data is offered; nothing may emerge afterwards.
    repeat (2) applyStimulus(0, 0, 1, 8'hAA, 1, acc);
    repeat (6) applyStimulus(1, 0, 0, 8'h00, 1, acc);

    // Back-to-back streaming.
    for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 1, W'(i), 1, acc);
    repeat (6) applyStimulus(1, 0, 0, 8'h00, 1, acc);

    // Backpressure until full, then the fifth item enters as the oldest leaves.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 8'h10 + W'(i), 0, acc);
    repeat (3) applyStimulus(1, 0, 1, 8'h14, 0, acc);
    applyStimulus(1, 0, 1, 8'h14, 1, acc);
    repeat (6) applyStimulus(1, 0, 0, 8'h00, 1, acc);

    // Bubble collapse under a stalled output.
    applyStimulus(1, 0, 1, 8'h21, 0, acc);
    repeat (2) applyStimulus(1, 0, 0, 8'h00, 0, acc);
    applyStimulus(1, 0, 1, 8'h22, 0, acc);
    repeat (4) applyStimulus(1, 0, 0, 8'h00, 0, acc);
    repeat (4) applyStimulus(1, 0, 0, 8'h00, 1, acc);

    // Flush with an item offered in the same cycle.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 8'h30 + W'(i), 0, acc);
    applyStimulus(1, 1, 1, 8'h33, 0, acc);
    applyStimulus(1, 0, 1, 8'h55, 1, acc);
    repeat (6) applyStimulus(1, 0, 0, 8'h00, 1, acc);

    // Reset in the middle of a stalled, full pipe.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 8'h60 + W'(i), 0, acc);
    applyStimulus(0, 0, 0, 8'h00, 0, acc);
    repeat (6) applyStimulus(1, 0, 0, 8'h00, 1, acc);

    // Random traffic with occasional flush and reset.
    nextData = W'($urandom);
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 3) != 0, nextData, $urandom_range(0, 2) != 0, acc);
      if (acc) nextData = W'($urandom);
    end
    repeat (8) applyStimulus(1, 0, 0, 8'h00, 1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
